// File: rtl/neuron_accumulator.sv
// Weighted-sum stage of a neuron: accumulates signed input*weight products, adds a bias,
// saturates to 32 bits and hands base plus power to the downstream shifter.
module neuron_accumulator #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ACC_W    = 40,
  parameter int unsigned N_INPUTS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] in_weight,
  input  logic              in_last,
  input  logic [31:0]       cfg_bias,
  input  logic [7:0]        cfg_power,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_base,
  output logic [7:0]        out_power,
  output logic              out_sat
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned CNT_W  = $clog2(N_INPUTS + 1);
  localparam bit          SingleBeat = (N_INPUTS == 1);

  localparam logic signed [ACC_W-1:0] MaxPos = {{(ACC_W - 31){1'b0}}, {31{1'b1}}};
  localparam logic signed [ACC_W-1:0] MinNeg = {{(ACC_W - 31){1'b1}}, {31{1'b0}}};

  typedef enum logic [1:0] {StIdle, StAccum, StDrain, StOut} state_e;

  state_e                    state_q, state_d;
  logic        [CNT_W-1:0]   count_q, count_d;
  logic signed [PROD_W-1:0]  p_q, prod;
  logic                      p_vld_q;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic        [7:0]         power_q;
  logic                      load_power;
  logic                      in_xfer, out_xfer;
  logic signed [ACC_W-1:0]   p_ext, bias_ext;
  logic        [31:0]        sat_base;
  logic                      sat_flag;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  assign prod     = PROD_W'($signed(in_data)) * PROD_W'($signed(in_weight));
  assign p_ext    = {{(ACC_W - PROD_W){p_q[PROD_W-1]}}, p_q};
  assign bias_ext = {{(ACC_W - 32){cfg_bias[31]}}, cfg_bias};

  // FSM next state and handshake
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    in_ready   = 1'b0;
    load_power = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_xfer) begin
          count_d    = CNT_W'(1);
          load_power = 1'b1;
          state_d    = (in_last || SingleBeat) ? StDrain : StAccum;
        end
      end
      StAccum: begin
        in_ready = 1'b1;
        if (in_xfer) begin
          count_d = count_q + CNT_W'(1);
          if (in_last || (count_q == CNT_W'(N_INPUTS - 1))) state_d = StDrain;
        end
      end
      StDrain: state_d = StOut;
      StOut: begin
        if (out_xfer) begin
          state_d = StIdle;
          count_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Accumulator next value; the last product lands together with the bias in DRAIN
  always_comb begin
    acc_d = acc_q;
    unique case (state_q)
      StDrain: acc_d = acc_q + (p_vld_q ? p_ext : '0) + bias_ext;
      StOut:   if (out_xfer) acc_d = '0;
      default: if (p_vld_q) acc_d = acc_q + p_ext;
    endcase
  end

  always_comb begin
    sat_base = acc_q[31:0];
    sat_flag = 1'b0;
    if (acc_q > MaxPos) begin
      sat_base = 32'h7FFF_FFFF;
      sat_flag = 1'b1;
    end else if (acc_q < MinNeg) begin
      sat_base = 32'h8000_0000;
      sat_flag = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      count_q <= '0;
      p_q     <= '0;
      p_vld_q <= 1'b0;
      acc_q   <= '0;
      power_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      p_vld_q <= in_xfer;
      acc_q   <= acc_d;
      if (in_xfer)    p_q     <= prod;
      if (load_power) power_q <= cfg_power;
    end
  end

  // Result registers load on the first OUT cycle, once acc holds the biased sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_base  <= '0;
      out_power <= '0;
      out_sat   <= 1'b0;
    end else if (state_q == StOut) begin
      if (!out_valid) begin
        out_valid <= 1'b1;
        out_base  <= sat_base;
        out_power <= power_q;
        out_sat   <= sat_flag;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  a_out_stable: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid && !out_ready |=> out_valid && $stable(out_base) && $stable(out_power)
                                 && $stable(out_sat));
  a_idle_acc_zero: assert property (@(posedge clk) disable iff (!rst_n)
    state_q == StIdle |-> acc_q == '0);
  a_no_accept_busy: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == StDrain || state_q == StOut) |-> !in_ready);

endmodule

// File: tb/tb_neuron_accumulator.sv
// Bench for neuron_accumulator: directed vector table, random vectors against a plain
// arithmetic model, plus backpressure and mid-vector reset sequences.
module tb_neuron_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_last;
  logic [15:0] in_data, in_weight;
  logic [31:0] cfg_bias;
  logic [7:0]  cfg_power;
  logic        out_valid, out_ready;
  logic [31:0] out_base;
  logic [7:0]  out_power;
  logic        out_sat;

  int checks = 0;
  int errors = 0;

  neuron_accumulator #(.DATA_W(16), .ACC_W(40), .N_INPUTS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_weight (in_weight),
    .in_last   (in_last),
    .cfg_bias  (cfg_bias),
    .cfg_power (cfg_power),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_base  (out_base),
    .out_power (out_power),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               n;
    logic [7:0][15:0] d;
    logic [7:0][15:0] w;
    bit               last;
    logic [31:0]      bias;
    logic [7:0]       power;
    logic [31:0]      exp_base;
    bit               exp_sat;
    int               bp;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(int n, int dv[8], int wv[8], bit last, logic [31:0] bias,
                               logic [7:0] pw, logic [31:0] eb, bit es, int bp);
    vec_t v;
    v.n = n;
    for (int i = 0; i < 8; i++) begin
      v.d[i] = 16'(dv[i]);
      v.w[i] = 16'(wv[i]);
    end
    v.last = last; v.bias = bias; v.power = pw;
    v.exp_base = eb; v.exp_sat = es; v.bp = bp;
    return v;
  endfunction

  // Reference: exact sum in 64-bit arithmetic, then clip to the 32-bit signed range
  function automatic void model(input vec_t v, output logic [31:0] b, output bit s);
    longint acc = 0;
    for (int i = 0; i < v.n; i++)
      acc += longint'($signed(v.d[i])) * longint'($signed(v.w[i]));
    acc += longint'($signed(v.bias));
    s = 1'b1;
    if (acc > 64'sd2147483647)       b = 32'h7FFF_FFFF;
    else if (acc < -64'sd2147483648) b = 32'h8000_0000;
    else begin
      b = acc[31:0];
      s = 1'b0;
    end
  endfunction

  task automatic drive_beat(input logic [15:0] d, input logic [15:0] w, input logic last,
                            input string tag);
    int waited = 0;
    in_valid = 1'b1; in_data = d; in_weight = w; in_last = last;
    do begin
      @(negedge clk);
      waited++;
    end while (!in_ready && waited < 30);
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL %s in_ready timeout: got 0 expected 1", tag);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_vector(input vec_t v, input bit bubbles, input string tag);
    int     n_neg = 0;
    logic   ir_drain = 1'b1;
    bit     stable = 1'b1;
    bit     ir_low = 1'b1;
    logic [31:0] b0;
    logic [7:0]  p0;
    logic        s0;
    cfg_power = v.power;
    out_ready = 1'b0;
    for (int i = 0; i < v.n; i++) begin
      if (bubbles && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      if (i == 0) cfg_power = v.power;
      else        cfg_power = 8'($urandom);
      cfg_bias = (i == v.n - 1) ? v.bias : 32'($urandom);
      drive_beat(v.d[i], v.w[i], v.last && (i == v.n - 1), tag);
    end
    // Bias is sampled in DRAIN, the cycle right after the last beat
    cfg_bias = v.bias;
    do begin
      @(negedge clk);
      n_neg++;
      if (n_neg == 1) ir_drain = in_ready;
      if (n_neg == 2) cfg_bias = 32'($urandom);
    end while (!out_valid && n_neg < 20);
    check({tag, " latency"}, 64'(n_neg), 64'd3);
    check({tag, " in_ready in drain"}, 64'(ir_drain), 64'd0);
    check({tag, " out_base"}, 64'(out_base), 64'(v.exp_base));
    check({tag, " out_power"}, 64'(out_power), 64'(v.power));
    check({tag, " out_sat"}, 64'(out_sat), 64'(v.exp_sat));
    if (v.bp > 0) begin
      b0 = out_base; p0 = out_power; s0 = out_sat;
      repeat (v.bp) begin
        @(negedge clk);
        if (!out_valid || out_base !== b0 || out_power !== p0 || out_sat !== s0) stable = 0;
        if (in_ready) ir_low = 0;
      end
      check({tag, " held under backpressure"}, 64'(stable), 64'd1);
      check({tag, " in_ready low under backpressure"}, 64'(ir_low), 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, " out_valid after accept"}, 64'(out_valid), 64'd0);
    check({tag, " in_ready after accept"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    vec_t        v;
    logic [31:0] eb;
    bit          es;
    int          zeros[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    int          ones[8]  = '{1, 0, 0, 0, 0, 0, 0, 0};
    int          ramp[8]  = '{1, 2, 3, 4, 5, 6, 7, 8};
    int          threes[8] = '{3, 3, 3, 3, 3, 3, 3, 3};
    int          pmax[8]  = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
    int          nmax[8]  = '{-32767, -32767, -32767, -32767, -32767, -32767, -32767, -32767};

    tbl[0] = mkv(3, '{1, 2, 3, 0, 0, 0, 0, 0}, '{4, 5, 6, 0, 0, 0, 0, 0}, 1, 32'd10, 8'h02,
                 32'd42, 0, 0);
    tbl[1] = mkv(2, '{-3, 7, 0, 0, 0, 0, 0, 0}, '{5, -2, 0, 0, 0, 0, 0, 0}, 1, 32'hFFFF_FFFF,
                 8'hFE, 32'hFFFF_FFE2, 0, 0);
    tbl[2] = mkv(8, pmax, pmax, 1, 32'h7FFF_FFFF, 8'h05, 32'h7FFF_FFFF, 1, 0);
    tbl[3] = mkv(8, nmax, pmax, 0, 32'h8000_0000, 8'h81, 32'h8000_0000, 1, 0);
    tbl[4] = mkv(8, ramp, threes, 0, 32'd5, 8'h80, 32'd113, 0, 0);
    tbl[5] = mkv(1, '{10, 0, 0, 0, 0, 0, 0, 0}, '{-10, 0, 0, 0, 0, 0, 0, 0}, 1, 32'd0,
                 8'h7F, 32'hFFFF_FF9C, 0, 5);
    tbl[6] = mkv(1, zeros, ones, 1, 32'h7FFF_FFFF, 8'h00, 32'h7FFF_FFFF, 0, 0);
    tbl[7] = mkv(1, zeros, ones, 1, 32'h8000_0000, 8'h01, 32'h8000_0000, 0, 0);
    tbl[8] = mkv(1, ones, ones, 1, 32'h7FFF_FFFF, 8'h03, 32'h7FFF_FFFF, 1, 0);
    tbl[9] = mkv(2, '{-32768, 5, 0, 0, 0, 0, 0, 0}, '{-32768, 1, 0, 0, 0, 0, 0, 0}, 1,
                 32'd0, 8'h10, 32'h4000_0005, 0, 1);

    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; in_weight = '0;
    cfg_bias = '0; cfg_power = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_base", 64'(out_base), 64'd0);
    check("reset out_power", 64'(out_power), 64'd0);
    check("reset out_sat", 64'(out_sat), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int t = 0; t < 10; t++) run_vector(tbl[t], 1'b0, $sformatf("vec%0d", t));

    // Mid-vector reset: three beats then async reset, followed by a clean {2}*{2} vector
    for (int i = 0; i < 3; i++) drive_beat(16'd1000, 16'd1000, 1'b0, "rst_beats");
    rst_n = 1'b0;
    #2;
    check("midreset out_valid", 64'(out_valid), 64'd0);
    check("midreset out_base", 64'(out_base), 64'd0);
    check("midreset out_power", 64'(out_power), 64'd0);
    check("midreset out_sat", 64'(out_sat), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_vector(mkv(1, '{2, 0, 0, 0, 0, 0, 0, 0}, '{2, 0, 0, 0, 0, 0, 0, 0}, 1, 32'd0, 8'h04,
                   32'd4, 0, 0), 1'b0, "post_reset");

    for (int r = 0; r < 40; r++) begin
      v.n = $urandom_range(1, 8);
      v.last = (v.n < 8) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 4) == 0) begin
          v.d[i] = $urandom_range(0, 1) ? 16'h7FFF : 16'h8000;
          v.w[i] = $urandom_range(0, 1) ? 16'h7FFF : 16'h8000;
        end else begin
          v.d[i] = 16'($urandom);
          v.w[i] = 16'($urandom);
        end
      end
      v.bias  = ($urandom_range(0, 3) == 0) ? 32'h7FFF_0000 ^ 32'($urandom_range(0, 255))
                                            : 32'($urandom);
      v.power = 8'($urandom);
      v.bp    = $urandom_range(0, 3);
      model(v, eb, es);
      v.exp_base = eb;
      v.exp_sat  = es;
      run_vector(v, 1'b1, $sformatf("rand%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
